// File: rtl/redun_mont_pkg.sv
// Shared parameters and types for the redundant-form Montgomery squaring datapath.
// A redundant word carries one extra bit; the value is sum(w[i] * 2^(i*WRD_BITS)).
package redun_mont_pkg;

  localparam int unsigned WRD_BITS = 16;
  localparam int unsigned NUM_WRDS = 4;
  localparam int unsigned BIN_BITS = NUM_WRDS * WRD_BITS;

  typedef logic [NUM_WRDS-1:0][WRD_BITS:0]   redun0_t;
  typedef logic [NUM_WRDS-1:0][WRD_BITS-1:0] bin_t;

  // Full-width arithmetic value of a redundant operand; top two bits are the carry-out.
  function automatic logic [BIN_BITS+1:0] to_binary(input redun0_t r);
    logic [BIN_BITS+1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < NUM_WRDS; i++) begin
      acc = acc + ((BIN_BITS+2)'(r[i]) << (i * WRD_BITS));
    end
    return acc;
  endfunction

endpackage

// File: rtl/redun_mont_collect_if.sv
// Result-collection bus between the squaring core / consumer and redun_mont_collect.
interface redun_mont_collect_if
  import redun_mont_pkg::*;
#(
  parameter int unsigned CNT_BITS = 64
) ();

  logic                i_start;
  logic [CNT_BITS-1:0] i_iter;
  redun0_t             i_mul;
  logic                i_mul_val;
  logic                i_rdy;
  logic                o_busy;
  logic [CNT_BITS-1:0] o_cnt;
  logic [BIN_BITS-1:0] o_dat;
  logic [1:0]          o_carry;
  logic                o_val;

  modport slave (
    input  i_start, i_iter, i_mul, i_mul_val, i_rdy,
    output o_busy, o_cnt, o_dat, o_carry, o_val
  );

  modport master (
    output i_start, i_iter, i_mul, i_mul_val, i_rdy,
    input  o_busy, o_cnt, o_dat, o_carry, o_val
  );

endinterface

// File: rtl/redun_carry_slice.sv
// One step of a word-serial carry walk: redundant word plus 2-bit carry in.
// The carry out never exceeds 2 when the carry in is at most 2.
module redun_carry_slice
  import redun_mont_pkg::*;
(
  input  logic [WRD_BITS:0]   i_word,
  input  logic [1:0]          i_carry,
  output logic [WRD_BITS-1:0] o_sum,
  output logic [1:0]          o_carry
);

  logic [WRD_BITS+1:0] w_full;

  always_comb begin
    w_full  = {1'b0, i_word} + {{WRD_BITS{1'b0}}, i_carry};
    o_sum   = w_full[WRD_BITS-1:0];
    o_carry = w_full[WRD_BITS+1:WRD_BITS];
  end

endmodule

// File: rtl/redun_mont_collect.sv
// Counts squaring-core result strobes, captures the programmed iteration, resolves it
// to binary one word per cycle and offers it under valid/ready. Never stalls the core.
module redun_mont_collect
  import redun_mont_pkg::*;
#(
  parameter int unsigned CNT_BITS = 64
) (
  input logic                  i_clk,
  input logic                  i_rst,
  redun_mont_collect_if.slave  io
);

  localparam int unsigned      K_BITS = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;
  localparam logic [K_BITS-1:0] K_LAST = K_BITS'(NUM_WRDS - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_COUNT   = 4'b0010,
    S_RESOLVE = 4'b0100,
    S_OUTPUT  = 4'b1000
  } state_t;

  state_t              r_state;
  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] r_tgt;
  redun0_t             r_buf;
  bin_t                r_dat;
  logic [K_BITS-1:0]   r_k;
  logic [1:0]          r_c;
  logic [1:0]          r_carry;
  logic                r_val;
  logic                r_busy;

  logic [WRD_BITS-1:0] w_sum;
  logic [1:0]          w_cout;

  redun_carry_slice u_slice (
    .i_word  (r_buf[r_k]),
    .i_carry (r_c),
    .o_sum   (w_sum),
    .o_carry (w_cout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tgt   <= '0;
      r_buf   <= '0;
      r_dat   <= '0;
      r_k     <= '0;
      r_c     <= '0;
      r_carry <= '0;
      r_val   <= 1'b0;
      r_busy  <= 1'b0;
    end else if (io.i_start) begin
      // Start wins over any coincident strobe or handshake, including mid-job aborts.
      r_state <= S_COUNT;
      r_tgt   <= (io.i_iter == '0) ? CNT_BITS'(1) : io.i_iter;
      r_cnt   <= '0;
      r_k     <= '0;
      r_c     <= '0;
      r_val   <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_COUNT: begin
          if (io.i_mul_val) begin
            if (r_cnt == r_tgt - CNT_BITS'(1)) begin
              r_buf   <= io.i_mul;
              r_cnt   <= r_tgt;
              r_k     <= '0;
              r_c     <= '0;
              r_state <= S_RESOLVE;
            end else if (r_cnt != '1) begin
              r_cnt <= r_cnt + CNT_BITS'(1);
            end
          end
        end
        S_RESOLVE: begin
          r_dat[r_k] <= w_sum;
          r_c        <= w_cout;
          if (r_k == K_LAST) begin
            r_carry <= w_cout;
            r_val   <= 1'b1;
            r_busy  <= 1'b0;
            r_k     <= '0;
            r_state <= S_OUTPUT;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_OUTPUT: begin
          if (io.i_rdy) begin
            r_val   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io.o_busy  = r_busy;
  assign io.o_cnt   = r_cnt;
  assign io.o_dat   = r_dat;
  assign io.o_carry = r_carry;
  assign io.o_val   = r_val;

endmodule

// File: tb/tb_redun_mont_collect.sv
// Bench for redun_mont_collect: vector table of jobs plus hand-written abort/reset sequences.
module tb_redun_mont_collect;
  import redun_mont_pkg::*;

  localparam int unsigned CNT_BITS = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  redun_mont_collect_if #(.CNT_BITS(CNT_BITS)) bus ();

  redun_mont_collect #(.CNT_BITS(CNT_BITS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io    (bus)
  );

  typedef struct {
    logic [BIN_BITS-1:0] dat;
    logic [1:0]          carry;
    logic [CNT_BITS-1:0] cnt;
  } exp_t;

  typedef struct {
    logic [CNT_BITS-1:0] iter;
    redun0_t             mul;
    int unsigned         rdy_wait;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input redun0_t w, input logic [CNT_BITS-1:0] cnt);
    logic [BIN_BITS+1:0] v;
    exp_t e;
    v = '0;
    for (int unsigned i = 0; i < NUM_WRDS; i++)
      v = v + ((BIN_BITS+2)'(w[i]) << (i * WRD_BITS));
    e.dat   = v[BIN_BITS-1:0];
    e.carry = v[BIN_BITS+1:BIN_BITS];
    e.cnt   = cnt;
    return e;
  endfunction

  function automatic redun0_t rnd_redun();
    redun0_t r;
    for (int unsigned i = 0; i < NUM_WRDS; i++) r[i] = (WRD_BITS+1)'($urandom);
    return r;
  endfunction

  task automatic start_job(input logic [CNT_BITS-1:0] iter, input string tag);
    bus.i_start   = 1'b1;
    bus.i_iter    = iter;
    bus.i_mul_val = 1'b1;
    bus.i_mul     = rnd_redun();
    step();
    bus.i_start   = 1'b0;
    bus.i_iter    = {$urandom, $urandom};
    bus.i_mul_val = 1'b0;
    chk({tag, "_start_cnt"}, bus.o_cnt, 0);
    chk({tag, "_start_busy"}, bus.o_busy, 1);
    chk({tag, "_start_val"}, bus.o_val, 0);
  endtask

  // Waits for o_val with a cycle budget, checks latency from capture, pops and compares.
  task automatic wait_and_pop(input string tag, output exp_t e);
    int n = 0;
    bus.i_mul_val = 1'b1;
    while (!bus.o_val && n < 50) begin
      bus.i_mul = rnd_redun();
      step();
      n++;
    end
    chk({tag, "_latency"}, n, NUM_WRDS);
    chk({tag, "_busy_at_val"}, bus.o_busy, 0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
      e = '{default: '0};
    end else begin
      e = sb.pop_front();
      chk({tag, "_dat"}, bus.o_dat, e.dat);
      chk({tag, "_carry"}, bus.o_carry, e.carry);
      chk({tag, "_cnt"}, bus.o_cnt, e.cnt);
    end
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int   tgt;
    exp_t e;
    tgt = (v.iter == 0) ? 1 : int'(v.iter);
    start_job(v.iter, tag);
    for (int s = 1; s <= tgt; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.i_mul_val = 1'b0;
        step();
      end
      bus.i_mul_val = 1'b1;
      bus.i_mul     = (s == tgt) ? v.mul : rnd_redun();
      if (s == tgt) sb.push_back(model(v.mul, CNT_BITS'(tgt)));
      step();
      chk({tag, "_strobe_cnt"}, bus.o_cnt, s);
    end
    wait_and_pop(tag, e);
    for (int unsigned c = 0; c < v.rdy_wait; c++) begin
      bus.i_mul = rnd_redun();
      step();
      chk({tag, "_hold_val"}, bus.o_val, 1);
      chk({tag, "_hold_dat"}, bus.o_dat, e.dat);
      chk({tag, "_hold_cnt"}, bus.o_cnt, e.cnt);
    end
    bus.i_rdy = 1'b1;
    step();
    bus.i_rdy = 1'b0;
    chk({tag, "_hs_val"}, bus.o_val, 0);
    chk({tag, "_hs_busy"}, bus.o_busy, 0);
    step();
    bus.i_mul_val = 1'b0;
    chk({tag, "_idle_cnt"}, bus.o_cnt, e.cnt);
    chk({tag, "_idle_val"}, bus.o_val, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t    e;
    redun0_t w;

    vecs[0] = '{iter: 3, mul: {17'h0000F, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF}, rdy_wait: 0};
    vecs[1] = '{iter: 2, mul: {17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF}, rdy_wait: 0};
    vecs[2] = '{iter: 4, mul: rnd_redun(), rdy_wait: 10};
    vecs[3] = '{iter: 0, mul: rnd_redun(), rdy_wait: 2};
    vecs[4] = '{iter: 5, mul: '0, rdy_wait: 1};
    vecs[5] = '{iter: 1, mul: {17'h10000, 17'h0FFFF, 17'h10000, 17'h0FFFF}, rdy_wait: 3};

    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_iter = '0; bus.i_mul = '0; bus.i_mul_val = 1'b0; bus.i_rdy = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_val", bus.o_val, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_cnt", bus.o_cnt, 0);
    chk("rst_carry", bus.o_carry, 0);
    chk("rst_dat", bus.o_dat, 0);

    bus.i_mul_val = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.i_mul_val = 1'b0;
    chk("idle_ignore_cnt", bus.o_cnt, 0);
    chk("idle_ignore_busy", bus.o_busy, 0);

    for (int i = 0; i < 6; i++) run_job(vecs[i], $sformatf("vec%0d", i));

    // Abort two cycles into RESOLVE; only the second strobe of the new job may come out.
    start_job(2, "abort");
    bus.i_mul_val = 1'b1; bus.i_mul = rnd_redun(); step();
    bus.i_mul = '0; step();
    bus.i_mul_val = 1'b0; step(); step();
    chk("abort_busy_resolve", bus.o_busy, 1);
    bus.i_start = 1'b1; bus.i_iter = 2; bus.i_mul_val = 1'b1;
    step();
    bus.i_start = 1'b0; bus.i_mul_val = 1'b0;
    chk("abort_cnt", bus.o_cnt, 0);
    chk("abort_val", bus.o_val, 0);
    chk("abort_busy", bus.o_busy, 1);
    bus.i_mul_val = 1'b1; bus.i_mul = rnd_redun(); step();
    chk("abort_cnt1", bus.o_cnt, 1);
    w = rnd_redun();
    bus.i_mul = w; sb.push_back(model(w, 2)); step();
    wait_and_pop("abort_new", e);
    bus.i_rdy = 1'b1; step(); bus.i_rdy = 1'b0; bus.i_mul_val = 1'b0;
    chk("abort_hs_val", bus.o_val, 0);

    // Start coincident with a handshake in OUTPUT, then reset while in OUTPUT.
    start_job(1, "restart");
    w = rnd_redun();
    bus.i_mul_val = 1'b1; bus.i_mul = w; sb.push_back(model(w, 1)); step();
    wait_and_pop("restart_first", e);
    bus.i_start = 1'b1; bus.i_rdy = 1'b1; bus.i_iter = 3;
    step();
    bus.i_start = 1'b0; bus.i_rdy = 1'b0;
    chk("restart_val", bus.o_val, 0);
    chk("restart_busy", bus.o_busy, 1);
    chk("restart_cnt", bus.o_cnt, 0);
    bus.i_mul = rnd_redun(); step();
    bus.i_mul = rnd_redun(); step();
    w = {17'h1FFFF, 17'h00001, 17'h1FFFF, 17'h1FFFF};
    bus.i_mul = w; sb.push_back(model(w, 3)); step();
    wait_and_pop("restart_second", e);
    rst = 1'b1; step(); rst = 1'b0;
    chk("orst_val", bus.o_val, 0);
    chk("orst_cnt", bus.o_cnt, 0);
    chk("orst_busy", bus.o_busy, 0);
    chk("orst_carry", bus.o_carry, 0);
    chk("orst_dat", bus.o_dat, 0);
    for (int i = 0; i < 3; i++) step();
    bus.i_mul_val = 1'b0;
    chk("orst_ignore_cnt", bus.o_cnt, 0);
    chk("orst_ignore_val", bus.o_val, 0);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
